// File: rtl/mem_mult_pkg.sv
// Shared types for the memory-mapped batch multiplier: FSM encoding and
// per-pair cycle cost.
package mem_mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MULT,
    FIX,
    STORE,
    DONE
  } state_t;

  // LOAD + STORE move 2*op_bytes bytes each, MULT takes 8*op_bytes, FIX one.
  function automatic int pair_cycles(input int op_bytes);
    return 4 * op_bytes + 8 * op_bytes + 1;
  endfunction

endpackage

// File: rtl/seq_mult.sv
// Shift-add multiplier on operand magnitudes; sign is reapplied on the output
// so the product is final in the cycle valid pulses.
module seq_mult #(
  parameter int OP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              is_signed,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [2*OP_W-1:0] prod,
  output logic              valid
);

  localparam int CNT_W = $clog2(OP_W + 1);

  logic [2*OP_W-1:0] acc;
  logic [2*OP_W-1:0] mcand;
  logic [OP_W-1:0]   mplier;
  logic [OP_W-1:0]   mag_a;
  logic [OP_W-1:0]   mag_b;
  logic [CNT_W-1:0]  cnt;
  logic              run;
  logic              neg;

  // Negating the most negative value wraps to 2**(OP_W-1), which is the
  // correct magnitude when read as unsigned.
  always_comb begin
    mag_a = (is_signed && a[OP_W-1]) ? -a : a;
    mag_b = (is_signed && b[OP_W-1]) ? -b : b;
    prod  = neg ? -acc : acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      neg    <= 1'b0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (go) begin
        acc    <= '0;
        mcand  <= {{OP_W{1'b0}}, mag_a};
        mplier <= mag_b;
        neg    <= is_signed & (a[OP_W-1] ^ b[OP_W-1]);
        cnt    <= '0;
        run    <= 1'b1;
      end else if (run) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(OP_W - 1)) begin
          run   <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_mult_engine.sv
// Batch multiplier acting as a byte-wide data-memory master: loads operand
// pairs, multiplies them, and writes big-endian products back.
module mem_mult_engine
  import mem_mult_pkg::*;
#(
  parameter int OP_BYTES  = 2,
  parameter int NUM_PAIRS = 16,
  parameter int SRC_BASE  = 0,
  parameter int DST_BASE  = 64,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              signed_mode,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  output logic              busy,
  output logic              done
);

  // Handshake: start high holds the engine idle; a falling edge of start (a
  // high level must be seen first) launches a run. start high while busy
  // aborts. done stays high until start is raised again.

  localparam int OP_W   = 8 * OP_BYTES;
  localparam int BYTES2 = 2 * OP_BYTES;
  localparam int CNT_W  = $clog2(OP_W + 1);
  localparam int PAIR_W = $clog2(NUM_PAIRS + 1);

  state_t             state;
  logic               start_q;
  logic               mode_q;
  logic [CNT_W-1:0]   cnt;
  logic [PAIR_W-1:0]  pair;
  logic [ADDR_W-1:0]  src_ptr;
  logic [ADDR_W-1:0]  dst_ptr;
  logic [2*OP_W-1:0]  opnd;
  logic [2*OP_W-1:0]  opnd_next;
  logic [2*OP_W-1:0]  st_sr;
  logic               mul_go;
  logic [2*OP_W-1:0]  mul_prod;
  logic               mul_valid;

  // The final operand byte is still on mem_rd_data when the multiplier is
  // started, so it is fed from the shift register's next value.
  always_comb begin
    opnd_next = {opnd[2*OP_W-9:0], mem_rd_data};
    mul_go    = (state == LOAD) && (cnt == CNT_W'(BYTES2 - 1));
  end

  seq_mult #(.OP_W(OP_W)) u_mult (
    .clk       (clk),
    .reset     (reset),
    .go        (mul_go),
    .is_signed (mode_q),
    .a         (opnd_next[2*OP_W-1:OP_W]),
    .b         (opnd_next[OP_W-1:0]),
    .prod      (mul_prod),
    .valid     (mul_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      mode_q      <= 1'b0;
      cnt         <= '0;
      pair        <= '0;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      opnd        <= '0;
      st_sr       <= '0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      start_q <= start;
      if (busy && start) begin
        state     <= IDLE;
        busy      <= 1'b0;
        done      <= 1'b0;
        mem_wr_en <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_q && !start) begin
              mode_q   <= signed_mode;
              pair     <= '0;
              cnt      <= '0;
              mem_addr <= ADDR_W'(SRC_BASE);
              src_ptr  <= ADDR_W'(SRC_BASE + 1);
              dst_ptr  <= ADDR_W'(DST_BASE);
              busy     <= 1'b1;
              state    <= LOAD;
            end
          end
          LOAD: begin
            opnd <= opnd_next;
            if (cnt == CNT_W'(BYTES2 - 1)) begin
              cnt   <= '0;
              state <= MULT;
            end else begin
              cnt      <= cnt + CNT_W'(1);
              mem_addr <= src_ptr;
              src_ptr  <= src_ptr + ADDR_W'(1);
            end
          end
          MULT: begin
            if (cnt == CNT_W'(OP_W - 1)) begin
              cnt   <= '0;
              state <= FIX;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          FIX: begin
            if (mul_valid) begin
              mem_wr_data <= mul_prod[2*OP_W-1 -: 8];
              st_sr       <= mul_prod << 8;
              mem_addr    <= dst_ptr;
              dst_ptr     <= dst_ptr + ADDR_W'(1);
              mem_wr_en   <= 1'b1;
              cnt         <= '0;
              state       <= STORE;
            end
          end
          STORE: begin
            if (cnt == CNT_W'(BYTES2 - 1)) begin
              mem_wr_en <= 1'b0;
              cnt       <= '0;
              pair      <= pair + PAIR_W'(1);
              if (pair == PAIR_W'(NUM_PAIRS - 1)) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                mem_addr <= src_ptr;
                src_ptr  <= src_ptr + ADDR_W'(1);
                state    <= LOAD;
              end
            end else begin
              mem_wr_data <= st_sr[2*OP_W-1 -: 8];
              st_sr       <= st_sr << 8;
              mem_addr    <= dst_ptr;
              dst_ptr     <= dst_ptr + ADDR_W'(1);
              cnt         <= cnt + CNT_W'(1);
            end
          end
          DONE: begin
            if (start) begin
              done  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_mult_engine.sv
// Directed bench for mem_mult_engine: default 16-bit instance plus a 24-bit,
// 4-pair instance, each with its own byte memory.
module tb_mem_mult_engine;
  import mem_mult_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start0, sm0, start1, sm1;
  logic [7:0] addr0, rd0, wd0, addr1, rd1, wd1;
  logic       we0, busy0, done0, we1, busy1, done1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic       poke_en0, poke_en1;
  logic [7:0] poke_a, poke_d;

  int wr_cnt0 = 0, bad0 = 0, done_wr0 = 0, wr_cnt1 = 0, bad1 = 0;
  int errors = 0, checks = 0;

  logic [31:0] exp_q[$];
  logic [47:0] exp_w[$];

  mem_mult_engine u0 (
    .clk(clk), .reset(reset), .start(start0), .signed_mode(sm0),
    .mem_addr(addr0), .mem_rd_data(rd0), .mem_wr_en(we0), .mem_wr_data(wd0),
    .busy(busy0), .done(done0)
  );

  mem_mult_engine #(.OP_BYTES(3), .NUM_PAIRS(4), .SRC_BASE(0), .DST_BASE(32), .ADDR_W(8)) u1 (
    .clk(clk), .reset(reset), .start(start1), .signed_mode(sm1),
    .mem_addr(addr1), .mem_rd_data(rd1), .mem_wr_en(we1), .mem_wr_data(wd1),
    .busy(busy1), .done(done1)
  );

  assign rd0 = mem0[addr0];
  assign rd1 = mem1[addr1];

  always @(posedge clk) begin
    if (poke_en0) mem0[poke_a] <= poke_d;
    else if (we0) begin
      mem0[addr0] <= wd0;
      wr_cnt0++;
      if (addr0 < 64 || addr0 > 127) bad0++;
      if (done0) done_wr0++;
    end
    if (poke_en1) mem1[poke_a] <= poke_d;
    else if (we1) begin
      mem1[addr1] <= wd1;
      wr_cnt1++;
      if (addr1 < 32 || addr1 > 55) bad1++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke0(input int a, input logic [7:0] d);
    poke_en0 = 1'b1; poke_a = 8'(a); poke_d = d;
    tick();
    poke_en0 = 1'b0;
  endtask

  task automatic poke1(input int a, input logic [7:0] d);
    poke_en1 = 1'b1; poke_a = 8'(a); poke_d = d;
    tick();
    poke_en1 = 1'b0;
  endtask

  task automatic put0(input int j, input logic [15:0] a, input logic [15:0] b);
    poke0(4*j,   a[15:8]); poke0(4*j+1, a[7:0]);
    poke0(4*j+2, b[15:8]); poke0(4*j+3, b[7:0]);
  endtask

  task automatic put1(input int j, input logic [23:0] a, input logic [23:0] b);
    poke1(6*j,   a[23:16]); poke1(6*j+1, a[15:8]); poke1(6*j+2, a[7:0]);
    poke1(6*j+3, b[23:16]); poke1(6*j+4, b[15:8]); poke1(6*j+5, b[7:0]);
  endtask

  task automatic clear_dst0();
    for (int i = 64; i < 128; i++) poke0(i, 8'hEE);
  endtask

  // Raise start for two cycles, drop it, then count cycles from LOAD entry to done.
  task automatic launch0(input logic sm, output int lat);
    int w;
    sm0 = sm; start0 = 1'b1;
    tick(); tick();
    start0 = 1'b0;
    w = 0;
    while (!busy0 && w < 5) begin tick(); w++; end
    lat = 0;
    while (!done0 && lat < 2000) begin tick(); lat++; end
  endtask

  function automatic logic [31:0] prod0(input int j);
    return {mem0[64+4*j], mem0[65+4*j], mem0[66+4*j], mem0[67+4*j]};
  endfunction

  function automatic logic [47:0] prod1(input int j);
    return {mem1[32+6*j], mem1[33+6*j], mem1[34+6*j],
            mem1[35+6*j], mem1[36+6*j], mem1[37+6*j]};
  endfunction

  task automatic load_run1();
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      case (k % 4)
        0: begin put0(k, 16'd3, 16'd5);          exp_q.push_back(32'h0000000F); end
        1: begin put0(k, 16'hFFF9, 16'h0009);    exp_q.push_back(32'hFFFFFFC1); end
        2: begin put0(k, 16'h0000, 16'hFFFF);    exp_q.push_back(32'h00000000); end
        default: begin put0(k, 16'h7FFF, 16'h7FFF); exp_q.push_back(32'h3FFF0001); end
      endcase
    end
    clear_dst0();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; sm0 = 1'b0; sm1 = 1'b0;
    poke_en0 = 1'b0; poke_en1 = 1'b0; poke_a = '0; poke_d = '0;
    repeat (3) tick();
    checks++;
    if ({busy0, done0, we0, addr0, wd0} !== 19'd0)
      $display("FAIL reset_outputs0: got %b expected 0", {busy0, done0, we0, addr0, wd0});
    checks++;
    if ({busy1, done1, we1, addr1, wd1} !== 19'd0)
      $display("FAIL reset_outputs1: got %b expected 0", {busy1, done1, we1, addr1, wd1});
    reset = 1'b0;
    repeat (20) tick();
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0)
      $display("FAIL no_launch_without_rise: busy0=%b busy1=%b expected 0", busy0, busy1);
  endtask

  task automatic test_signed_run();
    int lat;
    logic [31:0] e;
    load_run1();
    launch0(1'b1, lat);
    checks++;
    if (lat !== 400) begin errors++; $display("FAIL signed_latency: got %0d expected 400", lat); end
    for (int k = 0; k < 16; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (prod0(k) !== e) begin errors++; $display("FAIL signed_prod[%0d]: got %h expected %h", k, prod0(k), e); end
    end
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b1) begin
      errors++; $display("FAIL signed_done_flags: busy=%b done=%b expected 0/1", busy0, done0);
    end
  endtask

  task automatic test_back_to_back();
    int lat, w;
    logic [31:0] e;
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      case (k % 4)
        0: begin put0(k, 16'h8000, 16'h8000); exp_q.push_back(32'h40000000); end
        1: begin put0(k, 16'h8000, 16'h0001); exp_q.push_back(32'hFFFF8000); end
        2: begin put0(k, 16'h7FFF, 16'h8000); exp_q.push_back(32'hC0008000); end
        default: begin put0(k, 16'h0001, 16'hFFFF); exp_q.push_back(32'hFFFFFFFF); end
      endcase
    end
    checks++;
    if (done0 !== 1'b1) begin errors++; $display("FAIL b2b_done_held: got %b expected 1", done0); end
    sm0 = 1'b1; start0 = 1'b1;
    tick();
    checks++;
    if (done0 !== 1'b0) begin errors++; $display("FAIL b2b_done_clear: got %b expected 0", done0); end
    tick();
    start0 = 1'b0;
    w = 0;
    while (!busy0 && w < 5) begin tick(); w++; end
    lat = 0;
    while (!done0 && lat < 2000) begin tick(); lat++; end
    checks++;
    if (lat !== 400) begin errors++; $display("FAIL b2b_latency: got %0d expected 400", lat); end
    for (int k = 0; k < 16; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (prod0(k) !== e) begin errors++; $display("FAIL b2b_prod[%0d]: got %h expected %h", k, prod0(k), e); end
    end
  endtask

  task automatic test_unsigned();
    int lat;
    logic [31:0] e;
    start0 = 1'b1;
    tick();
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      case (k % 4)
        0: begin put0(k, 16'hFFFF, 16'hFFFF); exp_q.push_back(32'hFFFE0001); end
        1: begin put0(k, 16'h8000, 16'h8000); exp_q.push_back(32'h40000000); end
        2: begin put0(k, 16'hFFF9, 16'h0009); exp_q.push_back(32'h0008FFC1); end
        default: begin put0(k, 16'h0000, 16'h1234); exp_q.push_back(32'h00000000); end
      endcase
    end
    clear_dst0();
    launch0(1'b0, lat);
    checks++;
    if (lat !== 400) begin errors++; $display("FAIL unsigned_latency: got %0d expected 400", lat); end
    for (int k = 0; k < 16; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (prod0(k) !== e) begin errors++; $display("FAIL unsigned_prod[%0d]: got %h expected %h", k, prod0(k), e); end
    end
  endtask

  task automatic test_abort();
    int lat, w, dirty;
    logic [31:0] e;
    start0 = 1'b1;
    tick();
    load_run1();
    sm0 = 1'b1; start0 = 1'b1;
    tick(); tick();
    start0 = 1'b0;
    w = 0;
    while (!busy0 && w < 5) begin tick(); w++; end
    repeat (60) tick();
    start0 = 1'b1;
    tick();
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++; $display("FAIL abort_flags: busy=%b done=%b expected 0/0", busy0, done0);
    end
    repeat (5) tick();
    checks++;
    if (prod0(1) !== 32'hFFFFFFC1) begin errors++; $display("FAIL abort_pair1: got %h expected FFFFFFC1", prod0(1)); end
    dirty = 0;
    for (int i = 72; i < 128; i++) if (mem0[i] !== 8'hEE) dirty++;
    checks++;
    if (dirty !== 0) begin errors++; $display("FAIL abort_untouched: got %0d changed bytes expected 0", dirty); end
    launch0(1'b1, lat);
    checks++;
    if (lat !== 400) begin errors++; $display("FAIL relaunch_latency: got %0d expected 400", lat); end
    for (int k = 0; k < 16; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (prod0(k) !== e) begin errors++; $display("FAIL relaunch_prod[%0d]: got %h expected %h", k, prod0(k), e); end
    end
  endtask

  task automatic test_reset_mid_store();
    int w, snap;
    start0 = 1'b1; sm0 = 1'b1;
    tick(); tick();
    start0 = 1'b0;
    w = 0;
    while (!we0 && w < 100) begin tick(); w++; end
    checks++;
    if (we0 !== 1'b1) begin errors++; $display("FAIL store_reached: got %b expected 1", we0); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy0, done0, we0, addr0, wd0} !== 19'd0) begin
      errors++; $display("FAIL async_reset_outputs: got %b expected 0", {busy0, done0, we0, addr0, wd0});
    end
    snap = wr_cnt0;
    tick(); tick();
    reset = 1'b0;
    repeat (40) tick();
    checks++;
    if (wr_cnt0 !== snap || busy0 !== 1'b0) begin
      errors++; $display("FAIL post_reset_quiet: writes=%0d busy=%b expected %0d/0", wr_cnt0, busy0, snap);
    end
  endtask

  task automatic test_wide();
    int lat, w, first_wr;
    logic [47:0] e;
    exp_w.delete();
    put1(0, 24'h800000, 24'h800000); exp_w.push_back(48'h400000000000);
    put1(1, 24'h000003, 24'hFFFFFE); exp_w.push_back(48'hFFFFFFFFFFFA);
    put1(2, 24'h7FFFFF, 24'h7FFFFF); exp_w.push_back(48'h3FFFFF000001);
    put1(3, 24'hFFFFFF, 24'hFFFFFF); exp_w.push_back(48'h000000000001);
    sm1 = 1'b1; start1 = 1'b1;
    tick(); tick();
    start1 = 1'b0;
    w = 0;
    while (!busy1 && w < 5) begin tick(); w++; end
    lat = 0; first_wr = -1;
    while (!done1 && lat < 1000) begin
      tick(); lat++;
      if (we1 && first_wr < 0) first_wr = lat;
    end
    checks++;
    if (first_wr !== 31) begin errors++; $display("FAIL wide_first_write: got %0d expected 31", first_wr); end
    checks++;
    if (lat !== 148) begin errors++; $display("FAIL wide_latency: got %0d expected 148", lat); end
    for (int k = 0; k < 4; k++) begin
      e = exp_w.pop_front();
      checks++;
      if (prod1(k) !== e) begin errors++; $display("FAIL wide_prod[%0d]: got %h expected %h", k, prod1(k), e); end
    end
    repeat (20) tick();
    checks++;
    if (done1 !== 1'b1) begin errors++; $display("FAIL wide_done_held: got %b expected 1", done1); end
    start1 = 1'b1;
    tick();
    checks++;
    if (done1 !== 1'b0) begin errors++; $display("FAIL wide_done_clear: got %b expected 0", done1); end
  endtask

  task automatic test_write_hygiene();
    checks++;
    if (bad0 !== 0) begin errors++; $display("FAIL out_of_range_writes0: got %0d expected 0", bad0); end
    checks++;
    if (done_wr0 !== 0) begin errors++; $display("FAIL writes_while_done: got %0d expected 0", done_wr0); end
    checks++;
    if (bad1 !== 0) begin errors++; $display("FAIL out_of_range_writes1: got %0d expected 0", bad1); end
    checks++;
    if (wr_cnt1 !== 24) begin errors++; $display("FAIL write_count1: got %0d expected 24", wr_cnt1); end
  endtask

  initial begin
    test_reset();
    test_signed_run();
    test_back_to_back();
    test_unsigned();
    test_abort();
    test_reset_mid_store();
    test_wide();
    test_write_hygiene();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
